// File: rtl/ctrl_pkg.sv
// Shared types and sizing for the token-authenticated countdown controller.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the FSM state encoding and widths used by controller and down_counter8.
package ctrl_pkg;

    localparam int TOKEN_W   = 3;
    localparam int DATA_W    = 8;
    localparam int MAX_FAILS = 3;
    localparam int FAIL_W    = $clog2(MAX_FAILS + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AUTH = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        LOCK = 3'd4
    } state_t;

endpackage

// File: rtl/controller_down_counter8.sv
// Loadable down-counter holding the remaining count; saturates at zero.
// Latency: 1 clock from clr/load/en to count. Backpressure: none; clr beats load beats en.
// The zero flag is decoded from the count register.
module down_counter8
    import ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic              en,
    input  logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] count,
    output logic              zero
);

    assign zero = (count == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/controller.sv
// Token-checked countdown controller: authenticate, load TimeData, count it down.
// Latency: every transition and output update takes 1 clock; outputs are registered.
// Backpressure: none; dropping request aborts the session at the next edge.
module controller
    import ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               request,
    input  logic               confirm,
    input  logic [TOKEN_W-1:0] system_token,
    input  logic [TOKEN_W-1:0] user_token,
    input  logic [DATA_W-1:0]  TimeData,
    output logic [DATA_W-1:0]  data_P,
    output logic [DATA_W-1:0]  data_Q
);

    state_t            state, state_nxt;
    logic [FAIL_W-1:0] fail_cnt, fail_cnt_nxt;
    logic              q_clr, q_load, q_dec, q_zero;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fail_cnt <= '0;
            data_P   <= '0;
        end else begin
            state    <= state_nxt;
            fail_cnt <= fail_cnt_nxt;
            if (q_load) begin
                data_P <= TimeData;
            end
        end
    end

    // data_Q is only non-zero in RUN, so it is cleared on every exit from RUN.
    always_comb begin
        state_nxt    = state;
        fail_cnt_nxt = fail_cnt;
        q_clr        = 1'b0;
        q_load       = 1'b0;
        q_dec        = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    state_nxt = AUTH;
                end
            end
            AUTH: begin
                if (!request) begin
                    state_nxt = IDLE;
                end else if (confirm) begin
                    if (user_token == system_token) begin
                        fail_cnt_nxt = '0;
                        state_nxt    = LOAD;
                    end else begin
                        fail_cnt_nxt = fail_cnt + 1'b1;
                        if (fail_cnt_nxt == FAIL_W'(MAX_FAILS)) begin
                            state_nxt = LOCK;
                        end
                    end
                end
            end
            LOAD: begin
                if (!request) begin
                    state_nxt = IDLE;
                end else if (confirm) begin
                    q_load    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!request || q_zero) begin
                    q_clr     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    q_dec = 1'b1;
                end
            end
            LOCK: begin
                state_nxt = LOCK;
            end
            default: begin
                q_clr     = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    down_counter8 u_q_cnt (
        .clock    (clock),
        .reset    (reset),
        .clr      (q_clr),
        .load     (q_load),
        .en       (q_dec),
        .load_val (TimeData),
        .count    (data_Q),
        .zero     (q_zero)
    );

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: driver pushes model predictions, monitor pops and compares.
module tb_controller;

    localparam int FAILS_TO_LOCK = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       request = 1'b0;
    logic       confirm = 1'b0;
    logic [2:0] system_token = 3'b101;
    logic [2:0] user_token = 3'b000;
    logic [7:0] TimeData = 8'h00;
    logic [7:0] data_P, data_Q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] p;
        logic [7:0] q;
        string      tag;
    } exp_t;
    exp_t sb[$];

    // Session-level reference: is a session open, has the token been accepted,
    // is a countdown in progress, how many consecutive token failures so far.
    bit         m_locked, m_in_session, m_token_ok, m_counting;
    int         m_fails;
    logic [7:0] m_p;
    int         m_remaining;

    controller dut (
        .clock        (clock),
        .reset        (reset),
        .request      (request),
        .confirm      (confirm),
        .system_token (system_token),
        .user_token   (user_token),
        .TimeData     (TimeData),
        .data_P       (data_P),
        .data_Q       (data_Q)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_locked     = 0;
        m_in_session = 0;
        m_token_ok   = 0;
        m_counting   = 0;
        m_fails      = 0;
        m_p          = 8'h00;
        m_remaining  = 0;
    endfunction

    function automatic void end_session();
        m_in_session = 0;
        m_token_ok   = 0;
        m_counting   = 0;
        m_remaining  = 0;
    endfunction

    // Effect of one clock edge given the inputs presented before it.
    function automatic void model_edge(input bit req, input bit conf, input logic [2:0] ut,
                                       input logic [2:0] st, input logic [7:0] td);
        if (m_locked) return;
        if (!m_in_session) begin
            if (req) m_in_session = 1;
        end else if (!req) begin
            end_session();
        end else if (m_counting) begin
            if (m_remaining == 0) end_session();
            else m_remaining = m_remaining - 1;
        end else if (m_token_ok) begin
            if (conf) begin
                m_p         = td;
                m_remaining = td;
                m_counting  = 1;
            end
        end else if (conf) begin
            if (ut == st) begin
                m_token_ok = 1;
                m_fails    = 0;
            end else begin
                m_fails = m_fails + 1;
                if (m_fails == FAILS_TO_LOCK) m_locked = 1;
            end
        end
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.p   = m_p;
        e.q   = 8'(m_remaining);
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input bit req, input bit conf, input logic [2:0] ut,
                        input logic [7:0] td, input string tag);
        @(negedge clock);
        request    = req;
        confirm    = conf;
        user_token = ut;
        TimeData   = td;
        model_edge(req, conf, ut, system_token, td);
        push_exp(tag);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check({tag, "_rstP"}, data_P, 8'h00);
        check({tag, "_rstQ"}, data_Q, 8'h00);
        model_reset();
        @(negedge clock);
        request = 1'b0;
        confirm = 1'b0;
        reset   = 1'b1;
        model_edge(0, 0, user_token, system_token, TimeData);
        push_exp({tag, "_rel"});
    endtask

    task automatic session(input logic [7:0] td, input string tag);
        step(1, 0, 3'b000, 8'h00, {tag, "_req"});
        step(1, 1, system_token, 8'h00, {tag, "_auth"});
        step(1, 1, 3'b000, td, {tag, "_load"});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, "_P"}, data_P, e.p);
                check({e.tag, "_Q"}, data_Q, e.q);
            end
        end
    end

    initial begin : driver
        bit         req, conf;
        logic [2:0] ut;
        logic [7:0] td;

        model_reset();
        #2;
        check("t1_rstP", data_P, 8'h00);
        check("t1_rstQ", data_Q, 8'h00);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        model_edge(0, 0, user_token, system_token, TimeData);
        push_exp("t1_rel");
        repeat (4) step(0, 0, 3'b000, 8'h00, "t1_idle");

        // Full countdown from F2, confirm held across AUTH and LOAD.
        session(8'hF2, "t2");
        repeat (243) step(1, 0, 3'b000, 8'h00, "t2_run");
        repeat (2) step(0, 0, 3'b000, 8'h00, "t2_idle");

        // Three consecutive mismatches lock; later requests are ignored.
        step(1, 0, 3'b000, 8'h00, "t3_req");
        repeat (3) step(1, 1, 3'b100, 8'h00, "t3_bad");
        step(0, 0, 3'b000, 8'h00, "t3_drop");
        repeat (4) step(1, 1, 3'b101, 8'h55, "t3_locked");
        async_reset("t3");

        // Failures persist across sessions; reset clears them.
        step(1, 0, 3'b000, 8'h00, "t3b_req");
        step(1, 1, 3'b100, 8'h00, "t3b_bad1");
        step(0, 0, 3'b000, 8'h00, "t3b_drop");
        step(1, 0, 3'b000, 8'h00, "t3b_req2");
        step(1, 1, 3'b100, 8'h00, "t3b_bad2");
        async_reset("t3b");
        step(1, 0, 3'b000, 8'h00, "t3c_req");
        repeat (2) step(1, 1, 3'b110, 8'h00, "t3c_bad");
        step(1, 1, 3'b101, 8'h00, "t3c_good");
        step(1, 1, 3'b000, 8'h33, "t3c_load");
        repeat (4) step(1, 0, 3'b000, 8'h00, "t3c_run");
        step(0, 0, 3'b000, 8'h00, "t3c_drop");

        // Abort in the third RUN cycle.
        session(8'h10, "t4");
        repeat (2) step(1, 0, 3'b000, 8'h00, "t4_run");
        step(0, 0, 3'b000, 8'h00, "t4_abort");
        repeat (2) step(0, 0, 3'b000, 8'h00, "t4_idle");

        // Zero load: one RUN cycle, no underflow.
        session(8'h00, "t5");
        repeat (3) step(1, 0, 3'b000, 8'h00, "t5_run");
        step(0, 0, 3'b000, 8'h00, "t5_idle");

        // Asynchronous reset in the middle of a countdown.
        session(8'h40, "t6");
        repeat (5) step(1, 0, 3'b000, 8'h00, "t6_run");
        async_reset("t6");
        repeat (2) step(0, 0, 3'b000, 8'h00, "t6_idle");

        // Randomized blocks, each starting from a fresh reset and token.
        for (int blk = 0; blk < 16; blk++) begin
            system_token = 3'($urandom_range(0, 7));
            for (int i = 0; i < 150; i++) begin
                req  = ($urandom_range(0, 19) != 0);
                conf = 1'($urandom_range(0, 1));
                ut   = ($urandom_range(0, 3) != 0) ? system_token : 3'($urandom_range(0, 7));
                td   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 12));
                step(req, conf, ut, td, "rnd");
            end
            async_reset("rnd");
        end

        repeat (2) step(0, 0, 3'b000, 8'h00, "end_idle");
        @(posedge clock);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0 pending", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
